// File: rtl/execute_stage.sv
// Purpose: RV32IM execute stage (ALU, branch compare, store lane alignment, iterative mul/div) feeding the EX/MEM register.
// Latency: 1 cycle for non-M ops; 34 cycles for mul/div (33 stall cycles); 2 cycles for div-by-zero/overflow (1 stall cycle).
// Backpressure: EX_stall (combinational) holds ID/EX while mul/div is in flight; MA_stall freezes the EX/MEM register.
// Ports: clk/rst (sync, active-high); PC_in, instruction_in, ctrl_word_in, rs1_in, rs2_in, MA_stall in;
//        PC_out, instruction_out, ctrl_word_out, alu_output_out, br_en_out, rs2_out, mem_byte_enable_out, EX_stall out.

package rv32i_types;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SLL = 3'd1, ALU_SRA = 3'd2, ALU_SUB = 3'd3,
                           ALU_XOR = 3'd4, ALU_SRL = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7;
    localparam logic [2:0] CMP_BEQ = 3'b000, CMP_BNE = 3'b001, CMP_BLT = 3'b100,
                           CMP_BGE = 3'b101, CMP_BLTU = 3'b110, CMP_BGEU = 3'b111;
    localparam logic       MUX1_RS1 = 1'b0, MUX1_PC = 1'b1;
    localparam logic [2:0] MUX2_I = 3'd0, MUX2_U = 3'd1, MUX2_B = 3'd2,
                           MUX2_S = 3'd3, MUX2_J = 3'd4, MUX2_RS2 = 3'd5;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic       read;
        logic       write;
    } rv32i_control_word;
endpackage

module execute_stage
    import rv32i_types::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       instruction_in,
    input  rv32i_control_word ctrl_word_in,
    input  logic [31:0]       rs1_in,
    input  logic [31:0]       rs2_in,
    input  logic              MA_stall,
    output logic [31:0]       PC_out,
    output logic [31:0]       instruction_out,
    output rv32i_control_word ctrl_word_out,
    output logic [31:0]       alu_output_out,
    output logic              br_en_out,
    output logic [31:0]       rs2_out,
    output logic [3:0]        mem_byte_enable_out,
    output logic              EX_stall
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

    // ---------------- decode ----------------
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode = instruction_in[6:0];
    assign funct3 = instruction_in[14:12];
    assign funct7 = instruction_in[31:25];
    assign i_imm  = {{21{instruction_in[31]}}, instruction_in[30:20]};
    assign s_imm  = {{21{instruction_in[31]}}, instruction_in[30:25], instruction_in[11:7]};
    assign b_imm  = {{20{instruction_in[31]}}, instruction_in[7], instruction_in[30:25],
                     instruction_in[11:8], 1'b0};
    assign u_imm  = {instruction_in[31:12], 12'h000};
    assign j_imm  = {{12{instruction_in[31]}}, instruction_in[19:12], instruction_in[20],
                     instruction_in[30:21], 1'b0};

    // ---------------- ALU ----------------
    logic [31:0] op_a, op_b, alu_result;

    assign op_a = (ctrl_word_in.alumux1_sel == MUX1_PC) ? PC_in : rs1_in;

    always_comb begin
        op_b = rs2_in;
        case (ctrl_word_in.alumux2_sel)
            MUX2_I:  op_b = i_imm;
            MUX2_U:  op_b = u_imm;
            MUX2_B:  op_b = b_imm;
            MUX2_S:  op_b = s_imm;
            MUX2_J:  op_b = j_imm;
            default: op_b = rs2_in;
        endcase
    end

    always_comb begin
        alu_result = op_a + op_b;
        case (ctrl_word_in.aluop)
            ALU_SLL: alu_result = op_a << op_b[4:0];
            ALU_SRA: alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_SUB: alu_result = op_a - op_b;
            ALU_XOR: alu_result = op_a ^ op_b;
            ALU_SRL: alu_result = op_a >> op_b[4:0];
            ALU_OR:  alu_result = op_a | op_b;
            ALU_AND: alu_result = op_a & op_b;
            default: alu_result = op_a + op_b;
        endcase
    end

    // ---------------- compare ----------------
    // Immediate compares (slti/sltiu) use i_imm; branches and register compares use rs2.
    logic [31:0] cmp_b;
    logic        br_en;

    assign cmp_b = (ctrl_word_in.alumux2_sel == MUX2_I) ? i_imm : rs2_in;

    always_comb begin
        br_en = 1'b0;
        case (ctrl_word_in.cmpop)
            CMP_BEQ:  br_en = (rs1_in == cmp_b);
            CMP_BNE:  br_en = (rs1_in != cmp_b);
            CMP_BLT:  br_en = ($signed(rs1_in) < $signed(cmp_b));
            CMP_BGE:  br_en = ($signed(rs1_in) >= $signed(cmp_b));
            CMP_BLTU: br_en = (rs1_in < cmp_b);
            CMP_BGEU: br_en = (rs1_in >= cmp_b);
            default:  br_en = 1'b0;
        endcase
    end

    // ---------------- store lane alignment ----------------
    logic [1:0]  addr_lo;
    logic [3:0]  byte_en;
    logic [31:0] store_dat;

    assign addr_lo = alu_result[1:0];

    always_comb begin
        byte_en   = 4'b0000;
        store_dat = rs2_in;
        if (ctrl_word_in.write) begin
            case (funct3)
                3'b000: begin
                    byte_en   = 4'b0001 << addr_lo;
                    store_dat = rs2_in << {addr_lo, 3'b000};
                end
                3'b001: begin
                    byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
                    store_dat = rs2_in << {addr_lo, 3'b000};
                end
                default: byte_en = 4'b1111;
            endcase
        end else if (ctrl_word_in.read) begin
            byte_en = 4'b1111;
        end
    end

    // ---------------- mul/div ----------------
    logic        is_m, m_en, is_div, a_signed, b_signed, a_neg, b_neg;
    logic        div_by_zero, div_ovf, special;
    logic [31:0] mag_a, mag_b;

    assign is_m     = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
    assign m_en     = (ENABLE_M != 0) && is_m;
    assign is_div   = funct3[2];
    // mul/mulh/div/rem treat rs1 as signed; mulhsu additionally keeps rs1 signed but rs2 unsigned.
    assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed && rs1_in[31];
    assign b_neg    = b_signed && rs2_in[31];
    assign mag_a    = a_neg ? -rs1_in : rs1_in;
    assign mag_b    = b_neg ? -rs2_in : rs2_in;

    assign div_by_zero = is_div && (rs2_in == 32'h0000_0000);
    assign div_ovf     = is_div && !funct3[0] && (rs1_in == 32'h8000_0000) && (rs2_in == 32'hFFFF_FFFF);
    assign special     = div_by_zero || div_ovf;

    md_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, opnd;   // mul: {hi,lo}=product, opnd=multiplicand; div: hi=rem, lo=quot, opnd=divisor
    logic        res_neg, rem_neg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m_en) state_next = special ? DONE : BUSY;
            BUSY:    if (cnt == 5'd31) state_next = DONE;
            DONE:    if (!MA_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [32:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = div_shift - {1'b0, opnd};   // bit 32 set means the trial subtract borrowed

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 5'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            opnd    <= 32'd0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (m_en) begin
                    cnt <= 5'd0;
                    if (div_by_zero) begin
                        acc_lo  <= 32'hFFFF_FFFF;
                        acc_hi  <= rs1_in;
                        res_neg <= 1'b0;
                        rem_neg <= 1'b0;
                    end else if (div_ovf) begin
                        acc_lo  <= 32'h8000_0000;
                        acc_hi  <= 32'd0;
                        res_neg <= 1'b0;
                        rem_neg <= 1'b0;
                    end else begin
                        acc_hi  <= 32'd0;
                        acc_lo  <= is_div ? mag_a : mag_b;
                        opnd    <= is_div ? mag_b : mag_a;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc_hi <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                        acc_lo <= {acc_lo[30:0], ~div_diff[32]};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, md_result;

    assign prod_fix = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = res_neg ? -acc_lo : acc_lo;
    assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

    always_comb begin
        md_result = prod_fix[63:32];
        case (funct3)
            3'b000:         md_result = prod_fix[31:0];
            3'b100, 3'b101: md_result = quo_fix;
            3'b110, 3'b111: md_result = rem_fix;
            default:        md_result = prod_fix[63:32];
        endcase
    end

    assign EX_stall = m_en && (state != DONE);

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_out              <= 32'd0;
            instruction_out     <= 32'd0;
            ctrl_word_out       <= '0;
            alu_output_out      <= 32'd0;
            br_en_out           <= 1'b0;
            rs2_out             <= 32'd0;
            mem_byte_enable_out <= 4'b0000;
        end else if (!MA_stall && !EX_stall) begin
            PC_out              <= PC_in;
            instruction_out     <= instruction_in;
            ctrl_word_out       <= ctrl_word_in;
            alu_output_out      <= m_en ? md_result : alu_result;
            br_en_out           <= br_en;
            rs2_out             <= store_dat;
            mem_byte_enable_out <= byte_en;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    logic [31:0]       PC_in, instruction_in, rs1_in, rs2_in;
    rv32i_control_word ctrl_word_in;
    logic              MA_stall;
    logic [31:0]       PC_out, instruction_out, alu_output_out, rs2_out;
    rv32i_control_word ctrl_word_out;
    logic              br_en_out;
    logic [3:0]        mem_byte_enable_out;
    logic              EX_stall;

    int vectors = 0;
    int miscompares = 0;

    execute_stage #(.ENABLE_M(1)) dut (
        .clk(clk), .rst(rst), .PC_in(PC_in), .instruction_in(instruction_in),
        .ctrl_word_in(ctrl_word_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .MA_stall(MA_stall),
        .PC_out(PC_out), .instruction_out(instruction_out), .ctrl_word_out(ctrl_word_out),
        .alu_output_out(alu_output_out), .br_en_out(br_en_out), .rs2_out(rs2_out),
        .mem_byte_enable_out(mem_byte_enable_out), .EX_stall(EX_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word mk_cw(input logic [2:0] aluop, input logic [2:0] cmpop,
                                                input logic m1, input logic [2:0] m2,
                                                input logic rd, input logic wr);
        rv32i_control_word cw;
        cw.aluop = aluop; cw.cmpop = cmpop; cw.alumux1_sel = m1;
        cw.alumux2_sel = m2; cw.read = rd; cw.write = wr;
        return cw;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
        return {imm, 5'd1, f3, 5'd2, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd3, 5'd1, f3, 5'd4, opc};
    endfunction

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input rv32i_control_word cw,
                         input logic [31:0] a, input logic [31:0] b);
        PC_in = pc; instruction_in = ins; ctrl_word_in = cw; rs1_in = a; rs2_in = b;
    endtask

    task automatic issue_nop();
        issue(32'h0, enc_i(12'h000, 3'b000, 7'b0010011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_I, 1'b0, 1'b0), 32'h0, 32'h0);
    endtask

    // Counts consecutive EX_stall cycles from the current instruction; bounded at 100.
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (EX_stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
        int n;
        issue(32'h200, enc_r(7'b0000001, f3, 7'b0110011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_RS2, 1'b0, 1'b0), a, b);
        count_stalls(n);
        chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
        @(negedge clk);
        chk({tag, "_res"}, alu_output_out, exp_res);
        issue_nop();
    endtask

    initial begin
        int n;
        rst = 1'b1; MA_stall = 1'b0;
        issue(32'h0, 32'h0, '0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_alu", alu_output_out, 32'h0);
        chk("rst_be", 32'(mem_byte_enable_out), 32'h0);
        rst = 1'b0;

        // addi: 5 + (-3)
        issue(32'h100, enc_i(12'hFFD, 3'b000, 7'b0010011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_I, 1'b0, 1'b0), 32'd5, 32'h0);
        #1 chk("add_stall", 32'(EX_stall), 32'h0);
        @(negedge clk);
        chk("add_res", alu_output_out, 32'h2);
        chk("add_pc", PC_out, 32'h100);
        chk("add_instr", instruction_out, 32'hFFD08113);

        // sb to 0x1003
        issue(32'h104, enc_s(12'h003, 3'b000), mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_S, 1'b0, 1'b1),
              32'h1000, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_addr", alu_output_out, 32'h1003);
        chk("sb_be", 32'(mem_byte_enable_out), 32'h8);
        chk("sb_dat", rs2_out, 32'hAB00_0000);
        chk("sb_cw", 32'(ctrl_word_out), 32'(mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_S, 1'b0, 1'b1)));

        // sh to 0x1002
        issue(32'h108, enc_s(12'h002, 3'b001), mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_S, 1'b0, 1'b1),
              32'h1000, 32'h0000_00AB);
        @(negedge clk);
        chk("sh_be", 32'(mem_byte_enable_out), 32'hC);
        chk("sh_dat", rs2_out, 32'h00AB_0000);

        // sw to 0x1004
        issue(32'h10C, enc_s(12'h004, 3'b010), mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_S, 1'b0, 1'b1),
              32'h1000, 32'h1234_5678);
        @(negedge clk);
        chk("sw_be", 32'(mem_byte_enable_out), 32'hF);
        chk("sw_dat", rs2_out, 32'h1234_5678);

        // lw from 0x1004
        issue(32'h110, enc_i(12'h004, 3'b010, 7'b0000011), mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_I, 1'b1, 1'b0),
              32'h1000, 32'h0);
        @(negedge clk);
        chk("lw_be", 32'(mem_byte_enable_out), 32'hF);
        chk("lw_addr", alu_output_out, 32'h1004);

        // sra with shift amount taken from rs2[4:0] only
        issue(32'h114, enc_r(7'b0100000, 3'b101, 7'b0110011), mk_cw(ALU_SRA, CMP_BEQ, MUX1_RS1, MUX2_RS2, 1'b0, 1'b0),
              32'hFFFF_FF00, 32'h0000_0024);
        @(negedge clk);
        chk("sra_res", alu_output_out, 32'hFFFF_FFF0);
        chk("sra_be", 32'(mem_byte_enable_out), 32'h0);

        // auipc-style: PC + u_imm
        issue(32'h1000, {20'h12345, 5'd1, 7'b0010111}, mk_cw(ALU_ADD, CMP_BEQ, MUX1_PC, MUX2_U, 1'b0, 1'b0),
              32'h0, 32'h0);
        @(negedge clk);
        chk("auipc_res", alu_output_out, 32'h1234_6000);

        // compares
        issue(32'h118, enc_r(7'd0, 3'b100, 7'b1100011), mk_cw(ALU_ADD, CMP_BLT, MUX1_PC, MUX2_B, 1'b0, 1'b0),
              32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        chk("blt", 32'(br_en_out), 32'h1);
        issue(32'h11C, enc_r(7'd0, 3'b110, 7'b1100011), mk_cw(ALU_ADD, CMP_BLTU, MUX1_PC, MUX2_B, 1'b0, 1'b0),
              32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        chk("bltu", 32'(br_en_out), 32'h0);
        issue(32'h120, enc_r(7'd0, 3'b000, 7'b1100011), mk_cw(ALU_ADD, CMP_BEQ, MUX1_PC, MUX2_B, 1'b0, 1'b0),
              32'h55, 32'h55);
        @(negedge clk);
        chk("beq", 32'(br_en_out), 32'h1);
        issue(32'h124, enc_i(12'h005, 3'b010, 7'b0010011), mk_cw(ALU_ADD, CMP_BLT, MUX1_RS1, MUX2_I, 1'b0, 1'b0),
              32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        chk("slti", 32'(br_en_out), 32'h1);

        // mul/div
        run_m("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_m("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_m("div0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_m("rem0", 3'b110, 32'd7, 32'd0, 32'd7, 1);
        run_m("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_m("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_m("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_m("divneg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_m("remneg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

        // MA_stall held for 5 cycles while the mul sits in DONE
        issue(32'h300, enc_i(12'hFFD, 3'b000, 7'b0010011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_I, 1'b0, 1'b0), 32'd5, 32'h0);
        @(negedge clk);
        chk("pre_hold", alu_output_out, 32'h2);
        issue(32'h304, enc_r(7'b0000001, 3'b000, 7'b0110011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_RS2, 1'b0, 1'b0), 32'd7, 32'hFFFF_FFFD);
        count_stalls(n);
        chk("hold_stalls", 32'(n), 32'd33);
        MA_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_alu", alu_output_out, 32'h2);
            chk("hold_state", 32'(dut.state), 32'd2);
        end
        MA_stall = 1'b0;
        @(negedge clk);
        chk("release_res", alu_output_out, 32'hFFFF_FFEB);
        chk("release_pc", PC_out, 32'h304);
        chk("release_state", 32'(dut.state), 32'd0);
        issue(32'h308, enc_i(12'hFFD, 3'b000, 7'b0010011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_I, 1'b0, 1'b0), 32'd10, 32'h0);
        @(negedge clk);
        chk("next_res", alu_output_out, 32'h7);
        chk("next_pc", PC_out, 32'h308);

        // reset in BUSY cycle 10
        issue(32'h400, enc_r(7'b0000001, 3'b000, 7'b0110011),
              mk_cw(ALU_ADD, CMP_BEQ, MUX1_RS1, MUX2_RS2, 1'b0, 1'b0), 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstb_state", 32'(dut.state), 32'd0);
        chk("rstb_pc", PC_out, 32'h0);
        chk("rstb_instr", instruction_out, 32'h0);
        chk("rstb_cw", 32'(ctrl_word_out), 32'h0);
        chk("rstb_alu", alu_output_out, 32'h0);
        chk("rstb_rs2", rs2_out, 32'h0);
        chk("rstb_be", 32'(mem_byte_enable_out), 32'h0);
        chk("rstb_br", 32'(br_en_out), 32'h0);
        rst = 1'b0;
        run_m("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32IM pipeline, sitting between decode and `memory_access`. It does the following:
- Computes the ALU result, the branch compare, and the store byte-enables/aligned store data.
- Runs RV32M multiply/divide on an iterative radix-2 unit.
- Registers everything into the EX/MEM pipeline register consumed by `memory_access`.
- Raises `EX_stall` while a mul/div is in flight, and holds its register whenever `MA_stall` is high.

## Interface
Parameters:
- `ENABLE_M`, default 1. When 0, M-opcode instructions are treated as plain ALU ops and `EX_stall` is never asserted.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `PC_in`, in, 32: PC of the ID/EX instruction.
- `instruction_in`, in, 32: raw instruction; immediates and funct fields are decoded from it.
- `ctrl_word_in`, in, `rv32i_control_word`: uses fields `aluop`, `cmpop`, `alumux1_sel`, `alumux2_sel`, `read`, `write`.
- `rs1_in`, in, 32: rs1 operand, already forwarded.
- `rs2_in`, in, 32: rs2 operand, already forwarded.
- `MA_stall`, in, 1: memory stage busy; hold the EX/MEM register.
- `PC_out`, out, 32: registered PC.
- `instruction_out`, out, 32: registered instruction.
- `ctrl_word_out`, out, `rv32i_control_word`: registered control word.
- `alu_output_out`, out, 32: ALU or mul/div result; this is the memory address for loads/stores.
- `br_en_out`, out, 1: registered compare result.
- `rs2_out`, out, 32: store data, byte-lane aligned.
- `mem_byte_enable_out`, out, 4: byte enables.
- `EX_stall`, out, 1: combinational; upstream holds ID/EX while it is high.

## Operation
- **ALU operand muxing**
  - Operand A: `alumux1_sel` selects rs1 or PC.
  - Operand B: `alumux2_sel` selects the i/u/b/s/j immediate or rs2.
  - ALU ops: add, sll, sra, sub, xor, srl, or, and. Shift amount is B[4:0].
- **Compare**: `cmpop` selects beq/bne/blt/bge/bltu/bgeu on rs1 vs (rs2 or i_imm, per `alumux2_sel`).
- **Byte enables**, with a = ALU result[1:0]:
  - Stores: sb gives `4'b0001<<a`; sh gives `4'b0011<<a` (a[0] is ignored, a[1] is used); sw gives `4'b1111`.
  - Loads: `4'b1111`.
  - All other instructions: `4'b0000`.
- **Store data**: `rs2_out = rs2_in << (8*a)` for sb/sh; rs2 unshifted for sw and everything else.
- **M-instruction detection**: opcode `0110011` and funct7 `0000001`. funct3 0–7 selects mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- **Mul/div FSM**: IDLE, BUSY, DONE.
  - IDLE → BUSY when an M-instruction is present and is not a special case. On entry, latch operand magnitudes and result-sign flags, and clear the 5-bit counter.
  - IDLE → DONE directly for special cases:
    - Divide by zero: quotient `0xFFFFFFFF`, remainder = dividend.
    - div/rem of `0x80000000` by `-1`: quotient `0x80000000`, remainder 0.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. Move to DONE after 32 steps (counter wraps 31 → 0).
  - DONE: apply sign fixup and select the low/high product or quotient/remainder into the result mux. Go to IDLE in the same cycle the EX/MEM register captures. Stay in DONE while `MA_stall` is high.
- **`EX_stall`** = `ENABLE_M && M-instruction && state != DONE`.
- **EX/MEM register** loads when `!MA_stall && !EX_stall`; otherwise all outputs hold.

## Timing
- **Reset**: all outputs become 0 (`ctrl_word_out`, `instruction_out`, `PC_out`, `alu_output_out`, `rs2_out`, `mem_byte_enable_out`, `br_en_out`). FSM goes to IDLE and the counter to 0. A reset during BUSY or DONE aborts the operation.
- **Non-M instructions**: 1-cycle latency. Outputs are valid the cycle after capture.
- **Normal mul/div**:
  - `EX_stall` is high in cycle 0, the cycle the instruction appears.
  - BUSY occupies cycles 1–32.
  - DONE in cycle 33 with `EX_stall` low, so the register captures at the end of cycle 33 if `MA_stall` is low.
  - Total: 33 stall cycles.
- **Special-case divides**: 1 stall cycle (IDLE → DONE), captured at the end of cycle 1.
- **`MA_stall` during DONE**: the result is held, and capture happens the first cycle `MA_stall` is low.
- **`MA_stall` during BUSY**: iteration continues unaffected.
- **Operands**: latched at IDLE exit. Changes to `rs1_in`/`rs2_in` during BUSY have no effect.

## Test plan
- add: rs1=5, i_imm=−3 → `alu_output_out` = 2 one cycle later; `EX_stall` never asserted.
- sb: address `0x1003`, rs2=`0x000000AB` → `mem_byte_enable_out` = `4'b1000`, `rs2_out` = `0xAB000000`. Same with sh at address `0x1002` → `4'b1100`, `0x00AB0000`.
- mul 7×(−3) → `0xFFFFFFEB`; mulhu `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE`. Each shows exactly 33 `EX_stall` cycles before capture.
- div 7/0 → `0xFFFFFFFF`, rem 7/0 → 7, div `0x80000000`/(−1) → `0x80000000`; each with 1 stall cycle. divu 100/7 → 14, remu → 2.
- Hold `MA_stall` high for 5 cycles starting in DONE → outputs unchanged and FSM stays in DONE. Capture happens on release; the next instruction follows one cycle later.
- Assert `rst` in BUSY cycle 10 → all outputs 0 and FSM in IDLE. A fresh mul issued afterwards completes with full 33-cycle latency and the correct result.
